// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared types and constants for the instruction fetch stage.
//   RESET_PC_DEFAULT : default byte PC loaded on reset
//   INST_NOP         : canonical RISC-V NOP (addi x0, x0, 0)
//   fetch_entry_t    : one prefetch FIFO entry {inst, pc, fault}
package riscv_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;   // instruction word returned by the RAM
    logic [31:0] pc;     // byte PC the word was fetched from
    logic        fault;  // misaligned-fetch marker, inst is 0 when set
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of DEPTH fetch_entry_t entries.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : drop every buffered entry (wins over push/pop)
//   push       : write push_entry at the tail (accepted when not full or
//                when a pop frees a slot in the same cycle)
//   pop        : retire the head (ignored when empty)
//   count      : number of buffered entries, 0..DEPTH
//   empty      : count == 0
//   head       : entry at the head; don't-care while empty
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          empty,
  output fetch_entry_t  head
);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction fetch stage feeding the riscv execute core.
// Owns the byte PC, issues one word read per cycle to a synchronous
// instruction RAM and buffers returned words, tagged with their PC, in a
// prefetch FIFO (fetch_fifo).
//   clk, rst                    : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc : one-cycle pulse, flush and restart fetch
//   mem_req, mem_addr           : RAM read strobe and word index
//   mem_rdata                   : RAM data, valid the cycle after mem_req
//   inst_valid, inst, inst_pc   : FIFO head towards the core
//   inst_ready                  : core accepts the head this cycle
//   inst_fault                  : head is a misaligned-fetch marker
// Optional feature: define FETCH_MISALIGN_CHECK_EN to turn a misaligned
// redirect into a single fault entry followed by a fetch stall; without it
// redirect_pc[1:0] is forced to zero and inst_fault never asserts.
module riscv_fetch
  import riscv_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  input  logic              inst_ready,
  output logic              inst_fault
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic          stalled;        // fetch halted after a misaligned redirect
  logic          fault_pending;  // push the fault marker this cycle
  logic          misaligned;
  logic [31:0]   redirect_target;
  logic [CW-1:0] count;
  logic          empty;
  logic          pop;
  logic          push;
  logic [CW:0]   slots_used;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Handshake: the head transfers to the core in every cycle where
  // inst_valid & inst_ready are both high, including a redirect cycle.
  // While inst_valid & !inst_ready the head entry is held unchanged.
  assign pop = inst_valid & inst_ready;

  // Credit: a request is only issued if its word is guaranteed a slot,
  // counting the word already in flight and any slot freed by this pop.
  // pop implies count >= 1, so the subtraction cannot underflow.
  assign slots_used = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign mem_req    = !rst & !redirect_valid & !stalled &
                      (slots_used < (CW+1)'(DEPTH));
  assign mem_addr   = fetch_pc[ADDR_W-1:2];

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned      = (redirect_pc[1:0] != 2'b00);
  assign redirect_target = redirect_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stalled       <= 1'b0;
      fault_pending <= 1'b0;
    end else if (redirect_valid) begin
      stalled       <= misaligned;
      fault_pending <= misaligned;
    end else begin
      fault_pending <= 1'b0;
    end
  end
`else
  assign misaligned      = 1'b0;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign stalled         = 1'b0;
  assign fault_pending   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      // The pending RAM word belongs to the old stream and is discarded.
      // inflight_pc carries the faulting PC to the marker push.
      fetch_pc    <= redirect_target;
      inflight    <= 1'b0;
      inflight_pc <= redirect_target;
    end else begin
      inflight <= mem_req;
      if (mem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
    end
  end

  always_comb begin
    push_entry = '0;
    push       = (inflight | fault_pending) & !redirect_valid;
    if (fault_pending) begin
      push_entry.inst  = 32'h0;
      push_entry.pc    = inflight_pc;
      push_entry.fault = 1'b1;
    end else begin
      push_entry.inst  = mem_rdata;
      push_entry.pc    = inflight_pc;
      push_entry.fault = misaligned & 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .empty      (empty),
    .head       (head)
  );

  assign inst_valid = !empty;
  assign inst       = inst_valid ? head.inst : 32'h0;
  assign inst_pc    = inst_valid ? head.pc   : 32'h0;
  assign inst_fault = inst_valid & head.fault;

endmodule

// File: tb/tb_riscv_fetch.sv
module tb_riscv_fetch;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              mem_req;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_ready;
  logic              inst_fault;

  int checks;
  int failures;

  logic [31:0] ram [1024];

  riscv_fetch #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .inst_fault     (inst_fault)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous instruction RAM model
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= ram[mem_addr];
  end

  // expected RAM word for a byte PC (RAM wraps at 4 KiB)
  function automatic logic [31:0] w(input logic [31:0] pc);
    return 32'h5A00_0000 + {20'h0, pc[11:2], 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one cycle: drive inputs just after the edge, then settle
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_pc"}, inst_pc, pc);
    chk({tag, "_inst"}, inst, w(pc));
    chk({tag, "_fault"}, 32'(inst_fault), 32'd0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    mem_rdata      = 32'h0;
    rst            = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h5A00_0000 + 32'(i * 4);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_fault", 32'(inst_fault), 32'd0);

    // cycle 0: first request right after release
    rst = 1'b0;
    #1;
    chk("c0_req", 32'(mem_req), 32'd1);
    chk("c0_addr", 32'(mem_addr), 32'd0);
    step(1, 0, 0);  // cycle 1
    chk("c1_valid", 32'(inst_valid), 32'd0);
    chk("c1_addr", 32'(mem_addr), 32'd1);
    // cycles 2..5: A,B,C,D back to back
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0);
      chk_head("stream", 32'(k * 4));
    end

    // cycles 6..10: core stalls, head holds, credit runs out at cycle 8
    for (int c = 6; c <= 10; c++) begin
      step(0, 0, 0);
      chk_head("hold", 32'h10);
      chk("hold_req", 32'(mem_req), (c < 8) ? 32'd1 : 32'd0);
    end
    // cycles 11..13: release, no gap and nothing lost
    for (int c = 11; c <= 13; c++) begin
      step(1, 0, 0);
      chk_head("release", 32'(16 + (c - 11) * 4));
    end

    // redirect to 0 to set up a head at pc 4
    step(0, 1, 32'h0);     // 14
    chk("r0_req", 32'(mem_req), 32'd0);
    step(0, 0, 0);         // 15
    chk("r0_addr", 32'(mem_addr), 32'd0);
    step(0, 0, 0);         // 16
    step(1, 0, 0);         // 17
    chk_head("r0_first", 32'h0);
    // 18: redirect coinciding with the pop of pc 4
    step(1, 1, 32'h40);
    chk_head("popredir", 32'h4);
    chk("popredir_req", 32'(mem_req), 32'd0);
    step(1, 0, 0);         // 19
    chk("pr1_valid", 32'(inst_valid), 32'd0);
    chk("pr1_req", 32'(mem_req), 32'd1);
    chk("pr1_addr", 32'(mem_addr), 32'h10);
    step(1, 0, 0);         // 20
    chk("pr2_valid", 32'(inst_valid), 32'd0);
    // 21: first instruction of the new stream, then redirect to 0x200
    step(0, 1, 32'h200);
    chk_head("pr3", 32'h40);

    // build up 2 buffered + 1 in flight, then redirect to 0x80
    step(0, 0, 0);         // 22
    chk("b_addr", 32'(mem_addr), 32'h80);
    step(0, 0, 0);         // 23
    step(0, 0, 0);         // 24
    step(0, 1, 32'h80);    // 25
    chk_head("flush_head", 32'h200);
    chk("flush_req", 32'(mem_req), 32'd0);
    step(0, 0, 0);         // 26
    chk("f1_valid", 32'(inst_valid), 32'd0);
    chk("f1_addr", 32'(mem_addr), 32'h20);
    step(0, 0, 0);         // 27
    chk("f2_valid", 32'(inst_valid), 32'd0);
    step(1, 0, 0);         // 28
    chk_head("f3", 32'h80);
    step(1, 0, 0);         // 29
    chk_head("f4", 32'h84);
    step(1, 0, 0);         // 30
    chk_head("f5", 32'h88);

    // wrap at the RAM size
    step(1, 1, 32'hFF8);   // 31
    step(1, 0, 0);         // 32
    chk("wrap_a0", 32'(mem_addr), 32'h3FE);
    step(1, 0, 0);         // 33
    chk("wrap_a1", 32'(mem_addr), 32'h3FF);
    step(1, 0, 0);         // 34
    chk("wrap_a2", 32'(mem_addr), 32'h0);
    chk_head("wrap_h0", 32'hFF8);
    step(1, 0, 0);         // 35
    chk_head("wrap_h1", 32'hFFC);
    step(1, 0, 0);         // 36
    chk_head("wrap_h2", 32'h1000);
    chk("wrap_word0", inst, 32'h5A00_0000);

    // misaligned redirect
    step(0, 1, 32'h82);    // 37
`ifdef FETCH_MISALIGN_CHECK_EN
    step(0, 0, 0);         // 38
    chk("ma1_req", 32'(mem_req), 32'd0);
    chk("ma1_valid", 32'(inst_valid), 32'd0);
    for (int c = 39; c <= 40; c++) begin
      step(0, 0, 0);
      chk("ma_valid", 32'(inst_valid), 32'd1);
      chk("ma_fault", 32'(inst_fault), 32'd1);
      chk("ma_pc", inst_pc, 32'h82);
      chk("ma_inst", inst, 32'h0);
      chk("ma_req", 32'(mem_req), 32'd0);
    end
    step(0, 1, 32'h100);   // 41
    step(0, 0, 0);         // 42
    chk("res_req", 32'(mem_req), 32'd1);
    chk("res_addr", 32'(mem_addr), 32'h40);
    step(0, 0, 0);         // 43
    step(1, 0, 0);         // 44
    chk_head("resume", 32'h100);
`else
    step(0, 0, 0);         // 38
    chk("ma1_req", 32'(mem_req), 32'd1);
    chk("ma1_addr", 32'(mem_addr), 32'h20);
    step(0, 0, 0);         // 39
    chk("ma2_valid", 32'(inst_valid), 32'd0);
    step(1, 0, 0);         // 40
    chk_head("ma_forced", 32'h80);
`endif

    // reset asserted mid-operation drops everything immediately
    step(1, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_inst", inst, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
